// File: rtl/alu_hazard_ctrl_pkg.sv
// Shared CPU pipeline constants: register-index width, forward-select encodings
// and the load-use bubble counter width.
package alu_hazard_ctrl_pkg;

  localparam int unsigned NUM_REGS_DEF = 32;
  localparam int unsigned REG_IDX_W    = $clog2(NUM_REGS_DEF);
  localparam int unsigned FWD_SEL_W    = 2;
  localparam int unsigned STALL_CNT_W  = 16;

  // ALU operand source: register file, EX/MEM result, MEM/WB result
  localparam logic [FWD_SEL_W-1:0] FWD_REG = 2'd0;
  localparam logic [FWD_SEL_W-1:0] FWD_MEM = 2'd1;
  localparam logic [FWD_SEL_W-1:0] FWD_WB  = 2'd2;

endpackage

// File: rtl/fwd_sel_calc.sv
// Forward-select priority compare for one ALU operand: the youngest producer
// (currently in EX) wins over the older one (currently in MEM); x0 never forwards.
module fwd_sel_calc
  import alu_hazard_ctrl_pkg::*;
#(
  parameter int unsigned IDX_W = REG_IDX_W
) (
  input  logic                 id_valid_i,
  input  logic                 uses_i,
  input  logic [IDX_W-1:0]     rs_i,
  input  logic                 ex_valid_i,
  input  logic                 ex_regwrite_i,
  input  logic [IDX_W-1:0]     ex_rd_i,
  input  logic                 mem_valid_i,
  input  logic                 mem_regwrite_i,
  input  logic [IDX_W-1:0]     mem_rd_i,
  output logic [FWD_SEL_W-1:0] sel_c_o
);

  always_comb begin
    sel_c_o = FWD_REG;
    if (id_valid_i && uses_i && (rs_i != '0)) begin
      if (ex_valid_i && ex_regwrite_i && (ex_rd_i == rs_i)) begin
        sel_c_o = FWD_MEM;
      end else if (mem_valid_i && mem_regwrite_i && (mem_rd_i == rs_i)) begin
        sel_c_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/alu_hazard_ctrl.sv
// ALU hazard control: tracks the EX/MEM slots, registers operand forward selects
// for the instruction entering EX, and inserts one bubble on a load-use hazard.
module alu_hazard_ctrl
  import alu_hazard_ctrl_pkg::*;
#(
  parameter  int unsigned NUM_REGS = NUM_REGS_DEF,
  localparam int unsigned IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_n,
  input  logic                   i_IdValid,
  input  logic [IDX_W-1:0]       i_IdRs1,
  input  logic [IDX_W-1:0]       i_IdRs2,
  input  logic                   i_IdUsesRs1,
  input  logic                   i_IdUsesRs2,
  input  logic [IDX_W-1:0]       i_IdRd,
  input  logic                   i_IdRegWrite,
  input  logic                   i_IdIsLoad,
  input  logic                   i_MemStall,
  input  logic                   i_Flush,
  output logic [FWD_SEL_W-1:0]   o_ForASel,
  output logic [FWD_SEL_W-1:0]   o_ForBSel,
  output logic                   o_StallF,
  output logic                   o_ExValid,
  output logic [STALL_CNT_W-1:0] o_StallCnt
);

  logic                   ex_valid_q, ex_valid_d;
  logic [IDX_W-1:0]       ex_rd_q, ex_rd_d;
  logic                   ex_regwrite_q, ex_regwrite_d;
  logic                   ex_isload_q, ex_isload_d;
  logic                   mem_valid_q, mem_valid_d;
  logic [IDX_W-1:0]       mem_rd_q, mem_rd_d;
  logic                   mem_regwrite_q, mem_regwrite_d;
  logic [FWD_SEL_W-1:0]   fwd_a_q, fwd_a_d;
  logic [FWD_SEL_W-1:0]   fwd_b_q, fwd_b_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [FWD_SEL_W-1:0]   sel_a_c;
  logic [FWD_SEL_W-1:0]   sel_b_c;
  logic                   load_use_c;

  fwd_sel_calc #(.IDX_W(IDX_W)) u_fwd_a (
    .id_valid_i     (i_IdValid),
    .uses_i         (i_IdUsesRs1),
    .rs_i           (i_IdRs1),
    .ex_valid_i     (ex_valid_q),
    .ex_regwrite_i  (ex_regwrite_q),
    .ex_rd_i        (ex_rd_q),
    .mem_valid_i    (mem_valid_q),
    .mem_regwrite_i (mem_regwrite_q),
    .mem_rd_i       (mem_rd_q),
    .sel_c_o        (sel_a_c)
  );

  fwd_sel_calc #(.IDX_W(IDX_W)) u_fwd_b (
    .id_valid_i     (i_IdValid),
    .uses_i         (i_IdUsesRs2),
    .rs_i           (i_IdRs2),
    .ex_valid_i     (ex_valid_q),
    .ex_regwrite_i  (ex_regwrite_q),
    .ex_rd_i        (ex_rd_q),
    .mem_valid_i    (mem_valid_q),
    .mem_regwrite_i (mem_regwrite_q),
    .mem_rd_i       (mem_rd_q),
    .sel_c_o        (sel_b_c)
  );

  // A load in EX cannot forward yet: the dependent ID instruction must wait one cycle
  always_comb begin
    load_use_c = i_IdValid && ex_valid_q && ex_isload_q && ex_regwrite_q &&
                 (ex_rd_q != '0) &&
                 ((i_IdUsesRs1 && (i_IdRs1 == ex_rd_q)) ||
                  (i_IdUsesRs2 && (i_IdRs2 == ex_rd_q)));
  end

  assign o_StallF = i_Rst_n && load_use_c && !i_Flush && !i_MemStall;

  // Next-state: freeze > flush > load-use bubble > normal advance
  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_rd_d        = ex_rd_q;
    ex_regwrite_d  = ex_regwrite_q;
    ex_isload_d    = ex_isload_q;
    mem_valid_d    = mem_valid_q;
    mem_rd_d       = mem_rd_q;
    mem_regwrite_d = mem_regwrite_q;
    fwd_a_d        = fwd_a_q;
    fwd_b_d        = fwd_b_q;
    stall_cnt_d    = stall_cnt_q;
    if (!i_MemStall) begin
      mem_valid_d    = ex_valid_q;
      mem_rd_d       = ex_rd_q;
      mem_regwrite_d = ex_regwrite_q;
      if (i_Flush || load_use_c) begin
        ex_valid_d    = 1'b0;
        ex_rd_d       = '0;
        ex_regwrite_d = 1'b0;
        ex_isload_d   = 1'b0;
        fwd_a_d       = FWD_REG;
        fwd_b_d       = FWD_REG;
        if (!i_Flush && (stall_cnt_q != '1)) begin
          stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
      end else begin
        ex_valid_d    = i_IdValid;
        ex_rd_d       = i_IdRd;
        ex_regwrite_d = i_IdRegWrite;
        ex_isload_d   = i_IdIsLoad;
        fwd_a_d       = sel_a_c;
        fwd_b_d       = sel_b_c;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      ex_valid_q     <= 1'b0;
      ex_rd_q        <= '0;
      ex_regwrite_q  <= 1'b0;
      ex_isload_q    <= 1'b0;
      mem_valid_q    <= 1'b0;
      mem_rd_q       <= '0;
      mem_regwrite_q <= 1'b0;
      fwd_a_q        <= FWD_REG;
      fwd_b_q        <= FWD_REG;
      stall_cnt_q    <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_rd_q        <= ex_rd_d;
      ex_regwrite_q  <= ex_regwrite_d;
      ex_isload_q    <= ex_isload_d;
      mem_valid_q    <= mem_valid_d;
      mem_rd_q       <= mem_rd_d;
      mem_regwrite_q <= mem_regwrite_d;
      fwd_a_q        <= fwd_a_d;
      fwd_b_q        <= fwd_b_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign o_ForASel  = fwd_a_q;
  assign o_ForBSel  = fwd_b_q;
  assign o_ExValid  = ex_valid_q;
  assign o_StallCnt = stall_cnt_q;

endmodule

// File: tb/tb_alu_hazard_ctrl.sv
// Directed self-checking bench for alu_hazard_ctrl: forwarding distances,
// load-use bubble, flush/freeze priority, x0, counter saturation and reset.
module tb_alu_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_uses1;
  logic        id_uses2;
  logic [4:0]  id_rd;
  logic        id_rw;
  logic        id_ld;
  logic        mem_stall;
  logic        flush;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        stall_f;
  logic        ex_valid;
  logic [15:0] stall_cnt;

  int n_cmp;
  int n_bad;

  alu_hazard_ctrl dut (
    .i_Clk        (clk),
    .i_Rst_n      (rst_n),
    .i_IdValid    (id_valid),
    .i_IdRs1      (id_rs1),
    .i_IdRs2      (id_rs2),
    .i_IdUsesRs1  (id_uses1),
    .i_IdUsesRs2  (id_uses2),
    .i_IdRd       (id_rd),
    .i_IdRegWrite (id_rw),
    .i_IdIsLoad   (id_ld),
    .i_MemStall   (mem_stall),
    .i_Flush      (flush),
    .o_ForASel    (fwd_a),
    .o_ForBSel    (fwd_b),
    .o_StallF     (stall_f),
    .o_ExValid    (ex_valid),
    .o_StallCnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic ld);
    id_valid = v;  id_rs1 = rs1; id_uses1 = u1; id_rs2 = rs2; id_uses2 = u2;
    id_rd = rd;    id_rw = rw;   id_ld = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    nop();
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_stall = 1'b0; flush = 1'b0;
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1);
    tick(); tick();
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL reset_exvalid got %0b exp 0", ex_valid); end
    n_cmp++; if (fwd_a !== 2'd0) begin n_bad++; $display("FAIL reset_fwda got %0d exp 0", fwd_a); end
    n_cmp++; if (fwd_b !== 2'd0) begin n_bad++; $display("FAIL reset_fwdb got %0d exp 0", fwd_b); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt got %0h exp 0", stall_cnt); end
    n_cmp++; if (stall_f !== 1'b0) begin n_bad++; $display("FAIL reset_stallf got %0b exp 0", stall_f); end
    nop();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);   // ADD x5,x1,x2
    tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);   // ADD x6,x5,x5
    #1;
    n_cmp++; if (stall_f !== 1'b0) begin n_bad++; $display("FAIL b2b_stallf got %0b exp 0", stall_f); end
    tick();
    nop();
    #1;
    n_cmp++; if (ex_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_exvalid got %0b exp 1", ex_valid); end
    n_cmp++; if (fwd_a !== 2'd1) begin n_bad++; $display("FAIL b2b_fwda got %0d exp 1", fwd_a); end
    n_cmp++; if (fwd_b !== 2'd1) begin n_bad++; $display("FAIL b2b_fwdb got %0d exp 1", fwd_b); end
    n_cmp++; if (stall_f !== 1'b0) begin n_bad++; $display("FAIL b2b_stallf2 got %0b exp 0", stall_f); end
    drain();
  endtask

  task automatic test_distance2();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);   // write x7
    tick();
    set_id(1'b1, 5'd9, 1'b1, 5'd10, 1'b1, 5'd8, 1'b1, 1'b0);  // unrelated
    tick();
    set_id(1'b1, 5'd12, 1'b1, 5'd7, 1'b1, 5'd11, 1'b1, 1'b0); // read rs2 = x7
    tick();
    nop();
    n_cmp++; if (fwd_b !== 2'd2) begin n_bad++; $display("FAIL dist2_fwdb got %0d exp 2", fwd_b); end
    n_cmp++; if (fwd_a !== 2'd0) begin n_bad++; $display("FAIL dist2_fwda got %0d exp 0", fwd_a); end
    drain();
  endtask

  task automatic test_flush_load_use();
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);   // LW x3
    tick();
    set_id(1'b1, 5'd3, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0);   // ADD uses x3
    flush = 1'b1;
    #1;
    n_cmp++; if (stall_f !== 1'b0) begin n_bad++; $display("FAIL flushlu_stallf got %0b exp 0", stall_f); end
    tick();
    flush = 1'b0;
    nop();
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL flushlu_exvalid got %0b exp 0", ex_valid); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL flushlu_cnt got %0h exp 0", stall_cnt); end
    n_cmp++; if (fwd_a !== 2'd0) begin n_bad++; $display("FAIL flushlu_fwda got %0d exp 0", fwd_a); end
    drain();
  endtask

  task automatic test_load_use();
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);   // LW x3
    tick();
    set_id(1'b1, 5'd3, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0);   // ADD x4,x3,x2
    #1;
    n_cmp++; if (stall_f !== 1'b1) begin n_bad++; $display("FAIL lu_stallf got %0b exp 1", stall_f); end
    tick();
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL lu_bubble got %0b exp 0", ex_valid); end
    n_cmp++; if (stall_f !== 1'b0) begin n_bad++; $display("FAIL lu_stallf_clear got %0b exp 0", stall_f); end
    n_cmp++; if (stall_cnt !== 16'd1) begin n_bad++; $display("FAIL lu_cnt got %0h exp 1", stall_cnt); end
    tick();
    nop();
    n_cmp++; if (ex_valid !== 1'b1) begin n_bad++; $display("FAIL lu_exvalid got %0b exp 1", ex_valid); end
    n_cmp++; if (fwd_a !== 2'd2) begin n_bad++; $display("FAIL lu_fwda got %0d exp 2", fwd_a); end
    n_cmp++; if (fwd_b !== 2'd0) begin n_bad++; $display("FAIL lu_fwdb got %0d exp 0", fwd_b); end
    n_cmp++; if (stall_cnt !== 16'd1) begin n_bad++; $display("FAIL lu_cnt2 got %0h exp 1", stall_cnt); end
    drain();
  endtask

  task automatic test_memstall_x0();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);   // ADD x9
    tick();
    set_id(1'b1, 5'd9, 1'b1, 5'd1, 1'b1, 5'd10, 1'b1, 1'b0);  // ADD x10,x9,x1
    tick();
    set_id(1'b1, 5'd9, 1'b1, 5'd10, 1'b1, 5'd11, 1'b1, 1'b0); // ADD x11,x9,x10
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (fwd_a !== 2'd1) begin n_bad++; $display("FAIL hold_fwda[%0d] got %0d exp 1", i, fwd_a); end
      n_cmp++; if (fwd_b !== 2'd0) begin n_bad++; $display("FAIL hold_fwdb[%0d] got %0d exp 0", i, fwd_b); end
      n_cmp++; if (ex_valid !== 1'b1) begin n_bad++; $display("FAIL hold_exvalid[%0d] got %0b exp 1", i, ex_valid); end
    end
    mem_stall = 1'b0;
    tick();
    nop();
    n_cmp++; if (fwd_a !== 2'd2) begin n_bad++; $display("FAIL post_hold_fwda got %0d exp 2", fwd_a); end
    n_cmp++; if (fwd_b !== 2'd1) begin n_bad++; $display("FAIL post_hold_fwdb got %0d exp 1", fwd_b); end
    drain();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0);   // ADD x0
    tick();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd12, 1'b1, 1'b0);  // reads x0,x0
    tick();
    nop();
    n_cmp++; if (fwd_a !== 2'd0) begin n_bad++; $display("FAIL x0_fwda got %0d exp 0", fwd_a); end
    n_cmp++; if (fwd_b !== 2'd0) begin n_bad++; $display("FAIL x0_fwdb got %0d exp 0", fwd_b); end
    n_cmp++; if (ex_valid !== 1'b1) begin n_bad++; $display("FAIL x0_exvalid got %0b exp 1", ex_valid); end
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);   // LW x0
    tick();
    set_id(1'b1, 5'd0, 1'b1, 5'd2, 1'b1, 5'd13, 1'b1, 1'b0);
    #1;
    n_cmp++; if (stall_f !== 1'b0) begin n_bad++; $display("FAIL x0_load_stallf got %0b exp 0", stall_f); end
    drain();
  endtask

  task automatic test_saturation();
    force dut.stall_cnt_q = 16'hFFFE;
    tick();
    release dut.stall_cnt_q;
    tick();
    n_cmp++; if (stall_cnt !== 16'hFFFE) begin n_bad++; $display("FAIL sat_preload got %0h exp fffe", stall_cnt); end
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1); // LW x3
      tick();
      set_id(1'b1, 5'd3, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0);
      tick();
      tick();
      n_cmp++; if (stall_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL sat_cnt[%0d] got %0h exp ffff", i, stall_cnt); end
    end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);   // ADD x3
    tick();
    set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);   // LW x3,0(x3)
    tick();
    n_cmp++; if (fwd_a !== 2'd1) begin n_bad++; $display("FAIL rst_pre_fwda got %0d exp 1", fwd_a); end
    set_id(1'b1, 5'd3, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0);   // ADD uses x3
    #1;
    n_cmp++; if (stall_f !== 1'b1) begin n_bad++; $display("FAIL rst_pre_stallf got %0b exp 1", stall_f); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (stall_f !== 1'b0) begin n_bad++; $display("FAIL rst_asserted_stallf got %0b exp 0", stall_f); end
    tick();
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_exvalid got %0b exp 0", ex_valid); end
    n_cmp++; if (fwd_a !== 2'd0) begin n_bad++; $display("FAIL rst_mid_fwda got %0d exp 0", fwd_a); end
    n_cmp++; if (fwd_b !== 2'd0) begin n_bad++; $display("FAIL rst_mid_fwdb got %0d exp 0", fwd_b); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_mid_cnt got %0h exp 0", stall_cnt); end
    n_cmp++; if (stall_f !== 1'b0) begin n_bad++; $display("FAIL rst_mid_stallf got %0b exp 0", stall_f); end
    rst_n = 1'b1;
    nop();
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    mem_stall = 1'b0;
    flush = 1'b0;
    nop();
    test_reset();
    test_back_to_back();
    test_distance2();
    test_flush_load_use();
    test_load_use();
    test_memstall_x0();
    test_saturation();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_hazard_ctrl.md
ALU_HAZARD_CTRL -- requirements
Module: alu_hazard_ctrl

Interface
REQ-001 SHALL have param NUM_REGS, default 32, meaning architectural register count; the register index width is log2(NUM_REGS), 5 at default.
REQ-002 SHALL have i_Clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have i_Rst_n, input, 1, synchronous active-low reset.
REQ-004 SHALL have i_IdValid, input, 1, the ID-stage slot holds a real instruction.
REQ-005 SHALL have i_IdRs1 and i_IdRs2, input, 5 each, ID source register indices.
REQ-006 SHALL have i_IdUsesRs1 and i_IdUsesRs2, input, 1 each, the ID instruction actually reads that source.
REQ-007 SHALL have i_IdRd, input, 5, the ID destination index.
REQ-008 SHALL have i_IdRegWrite, input, 1, and i_IdIsLoad, input, 1, for ID writeback and load type.
REQ-009 SHALL have i_MemStall, input, 1, global pipeline freeze from the memory interface.
REQ-010 SHALL have i_Flush, input, 1, taken branch resolved in EX; kills the ID instruction.
REQ-011 SHALL have o_ForASel and o_ForBSel, output, 2 each, registered ALU operand forward selects for the instruction in EX.
REQ-012 SHALL have o_StallF, output, 1, combinational hold for PC and the IF/ID register.
REQ-013 SHALL have o_ExValid, output, 1, the EX slot holds a real instruction; 0 means a bubble.
REQ-014 SHALL have o_StallCnt, output, 16, saturating count of load-use bubbles.

Function
REQ-015 SHALL use select encoding 0 = register-file operand, 1 = EX/MEM result (producer now in MEM), 2 = MEM/WB result (producer now in WB); 3 is never driven.
REQ-016 SHALL track two internal slots: EX {valid, rd, regwrite, isload} and MEM {valid, rd, regwrite}.
REQ-017 SHALL, per operand X in {1,2}, when the ID instruction is valid and uses RsX and RsX != 0, compute sel 1 if EX.valid & EX.regwrite & EX.rd == RsX; otherwise sel 2 if MEM.valid & MEM.regwrite & MEM.rd == RsX; otherwise sel 0.
REQ-018 SHALL give the EX match priority over the MEM match, so the youngest producer wins.
REQ-019 SHALL never forward register 0; rs or rd equal to 0 always yields sel 0.
REQ-020 SHALL define loadUse = i_IdValid & EX.valid & EX.isload & EX.regwrite & EX.rd != 0 & (uses1 & rs1 == EX.rd | uses2 & rs2 == EX.rd).
REQ-021 SHALL apply edge updates in priority order, highest first:
- (a) i_MemStall = 1: all slots, selects and counter hold.
- (b) i_Flush = 1: MEM <= EX; EX <= bubble; selects <= 0.
- (c) loadUse = 1: MEM <= EX; EX <= bubble; selects <= 0; counter += 1.
- (d) otherwise: MEM <= EX; EX <= ID fields with valid = i_IdValid; selects <= computed values, or 0 if the ID slot is invalid.
REQ-022 SHALL drive o_StallF = loadUse & ~i_Flush & ~i_MemStall; flush overrides the stall.
REQ-023 SHALL give forward selects a latency of one cycle, ID to EX; they are valid in the same cycle o_ExValid = 1.
REQ-024 SHALL clear the load stall automatically after exactly one bubble, since the load moves to MEM and its data is forwarded via sel 2 next cycle.
REQ-025 SHALL saturate o_StallCnt at 0xFFFF with no wrap.
REQ-026 SHALL not forward a WB-stage producer to an ID consumer; the register file provides write-before-read bypass.

Reset
REQ-027 SHALL, when i_Rst_n = 0 at an edge: EX.valid = 0, MEM.valid = 0, o_ForASel = 0, o_ForBSel = 0, o_ExValid = 0, o_StallCnt = 0; reset overrides all other inputs, including mid-stall.
REQ-028 SHALL hold o_StallF = 0 while reset is asserted, since the slots are invalid.

Structure
REQ-029 SHALL place the FWD_REG/FWD_MEM/FWD_WB select constants and the register-index width in the shared CPU package used by the ALU.
REQ-030 SHALL implement the per-operand priority compare as one sub-module, fwd_sel_calc, instantiated twice (A and B).

Verification
REQ-031 SHALL cover back-to-back ALU ops: ADD x5 then ADD x6,x5,x5 -> next cycle o_ForASel = 1, o_ForBSel = 1, o_StallF never 1.
REQ-032 SHALL cover distance 2: write x7, unrelated op, then read rs2 = x7 -> o_ForBSel = 2, o_ForASel = 0.
REQ-033 SHALL cover load-use: LW x3, then ADD rs1 = x3 -> o_StallF = 1 for one cycle, o_ExValid = 0 next cycle, then o_ForASel = 2, o_StallCnt = 1.
REQ-034 SHALL cover flush during load-use: same as REQ-033 with i_Flush = 1 in the hazard cycle -> o_StallF = 0, EX bubble, o_StallCnt = 0.
REQ-035 SHALL cover MemStall hold and x0: i_MemStall = 1 for 3 cycles mid-sequence -> outputs unchanged; producer rd = 0 followed by consumer rs1 = 0 -> o_ForASel = 0.
REQ-036 SHALL cover saturation and reset: preload o_StallCnt to 0xFFFE, then 3 load-use hazards -> 0xFFFF; i_Rst_n = 0 mid-stall -> all outputs 0 at the next edge.
